// File: rtl/jtag_scan_ctrl.sv
// jtag_scan_ctrl: command sequencer in front of the JTAG shift engine.
// Takes a host command (instruction + data + DR length) and issues an optional
// IR scan followed by a DR scan to the engine. It then returns the captured DR
// bits, or an error, on a valid/ready response channel. The last loaded
// instruction is cached so that a repeat of the same IR skips the IR scan.
module jtag_scan_ctrl #(
    parameter int IR_W    = 10,
    parameter int DR_W    = 8,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active-low
    // host command channel
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [IR_W-1:0]  cmd_ir,
    input  logic [DR_W-1:0]  cmd_dr,
    input  logic [LEN_W-1:0] cmd_dr_len,
    input  logic             cmd_force_ir,
    // host response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DR_W-1:0]  rsp_data,
    output logic             rsp_err,
    // shift engine interface
    output logic             eng_work,
    output logic             eng_op,
    output logic [LEN_W-1:0] eng_len,
    output logic [IR_W-1:0]  eng_ir,
    output logic [DR_W-1:0]  eng_dr,
    input  logic             eng_done,
    input  logic [DR_W-1:0]  eng_cap
);

    // Watchdog width does not depend on LEN_W; one spare bit lets it saturate
    // past TIMEOUT-1 without wrapping. TIMEOUT==0 disables expiry entirely.
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = '1;
    localparam logic [LEN_W-1:0] IR_LEN = LEN_W'(IR_W);
    localparam logic [LEN_W-1:0] DR_MAX = LEN_W'(DR_W);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IR_GO   = 3'd1,
        IR_WAIT = 3'd2,
        DR_GO   = 3'd3,
        DR_WAIT = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [DR_W-1:0]  rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             eng_work_q, eng_work_d;
    logic             eng_op_q, eng_op_d;
    logic [LEN_W-1:0] eng_len_q, eng_len_d;
    logic [IR_W-1:0]  eng_ir_q, eng_ir_d;
    logic [DR_W-1:0]  eng_dr_q, eng_dr_d;
    logic [IR_W-1:0]  ir_q, ir_d;
    logic [DR_W-1:0]  dr_q, dr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [IR_W-1:0]  cached_ir_q, cached_ir_d;
    logic             ir_cache_valid_q, ir_cache_valid_d;
    logic [WD_W-1:0]  wd_q, wd_d;

    logic             cmd_fire;
    logic             cmd_len_bad;
    logic             cache_hit;
    logic             wd_expired;
    logic [WD_W-1:0]  wd_inc;
    logic [DR_W-1:0]  cap_mask;

    assign cmd_fire    = cmd_valid && cmd_ready_q;
    assign cmd_len_bad = (cmd_dr_len == '0) || (cmd_dr_len > DR_MAX);
    assign cache_hit   = ir_cache_valid_q && (cached_ir_q == cmd_ir) && !cmd_force_ir;
    assign wd_expired  = (TIMEOUT != 0) && (wd_q == WD_LAST);
    assign wd_inc      = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;

    // Captured bits beyond the requested DR length are not meaningful; mask them.
    for (genvar gi = 0; gi < DR_W; gi++) begin : g_cap_mask
        assign cap_mask[gi] = (len_q > LEN_W'(gi));
    end

    // Next-state and next-output logic. Outputs are computed for the state being
    // entered so that the registered outputs line up with the state register.
    always_comb begin
        state_d          = state_q;
        cmd_ready_d      = cmd_ready_q;
        rsp_valid_d      = rsp_valid_q;
        rsp_data_d       = rsp_data_q;
        rsp_err_d        = rsp_err_q;
        eng_work_d       = 1'b0;
        eng_op_d         = eng_op_q;
        eng_len_d        = eng_len_q;
        eng_ir_d         = eng_ir_q;
        eng_dr_d         = eng_dr_q;
        ir_d             = ir_q;
        dr_d             = dr_q;
        len_d            = len_q;
        cached_ir_d      = cached_ir_q;
        ir_cache_valid_d = ir_cache_valid_q;
        wd_d             = wd_q;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    ir_d        = cmd_ir;
                    dr_d        = cmd_dr;
                    len_d       = cmd_dr_len;
                    cmd_ready_d = 1'b0;
                    if (cmd_len_bad) begin
                        // Illegal length: answer immediately, engine untouched.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end else if (cache_hit) begin
                        state_d    = DR_GO;
                        eng_work_d = 1'b1;
                        eng_op_d   = 1'b1;
                        eng_len_d  = cmd_dr_len;
                        eng_dr_d   = cmd_dr;
                    end else begin
                        state_d    = IR_GO;
                        eng_work_d = 1'b1;
                        eng_op_d   = 1'b0;
                        eng_len_d  = IR_LEN;
                        eng_ir_d   = cmd_ir;
                    end
                end
            end

            IR_GO: begin
                wd_d    = '0;
                state_d = IR_WAIT;
            end

            IR_WAIT: begin
                // eng_done takes priority over a simultaneous watchdog expiry.
                if (eng_done) begin
                    cached_ir_d      = ir_q;
                    ir_cache_valid_d = 1'b1;
                    state_d          = DR_GO;
                    eng_work_d       = 1'b1;
                    eng_op_d         = 1'b1;
                    eng_len_d        = len_q;
                    eng_dr_d         = dr_q;
                end else if (wd_expired) begin
                    ir_cache_valid_d = 1'b0;
                    state_d          = RESP;
                    rsp_valid_d      = 1'b1;
                    rsp_err_d        = 1'b1;
                    rsp_data_d       = '0;
                end else begin
                    wd_d = wd_inc;
                end
            end

            DR_GO: begin
                wd_d    = '0;
                state_d = DR_WAIT;
            end

            DR_WAIT: begin
                if (eng_done) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = eng_cap & cap_mask;
                end else if (wd_expired) begin
                    // Engine state is unknown after a timeout; force a fresh IR scan.
                    ir_cache_valid_d = 1'b0;
                    state_d          = RESP;
                    rsp_valid_d      = 1'b1;
                    rsp_err_d        = 1'b1;
                    rsp_data_d       = '0;
                end else begin
                    wd_d = wd_inc;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State, latched command, IR cache, watchdog and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            cmd_ready_q      <= 1'b1;
            rsp_valid_q      <= 1'b0;
            rsp_data_q       <= '0;
            rsp_err_q        <= 1'b0;
            eng_work_q       <= 1'b0;
            eng_op_q         <= 1'b0;
            eng_len_q        <= '0;
            eng_ir_q         <= '0;
            eng_dr_q         <= '0;
            ir_q             <= '0;
            dr_q             <= '0;
            len_q            <= '0;
            cached_ir_q      <= '0;
            ir_cache_valid_q <= 1'b0;
            wd_q             <= '0;
        end else begin
            state_q          <= state_d;
            cmd_ready_q      <= cmd_ready_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_data_q       <= rsp_data_d;
            rsp_err_q        <= rsp_err_d;
            eng_work_q       <= eng_work_d;
            eng_op_q         <= eng_op_d;
            eng_len_q        <= eng_len_d;
            eng_ir_q         <= eng_ir_d;
            eng_dr_q         <= eng_dr_d;
            ir_q             <= ir_d;
            dr_q             <= dr_d;
            len_q            <= len_d;
            cached_ir_q      <= cached_ir_d;
            ir_cache_valid_q <= ir_cache_valid_d;
            wd_q             <= wd_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign eng_work  = eng_work_q;
    assign eng_op    = eng_op_q;
    assign eng_len   = eng_len_q;
    assign eng_ir    = eng_ir_q;
    assign eng_dr    = eng_dr_q;

endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// Directed testbench for jtag_scan_ctrl; the bench plays the shift engine.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_jtag_scan_ctrl;

    localparam int IR_W    = 10;
    localparam int DR_W    = 8;
    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [IR_W-1:0]  cmd_ir = '0;
    logic [DR_W-1:0]  cmd_dr = '0;
    logic [LEN_W-1:0] cmd_dr_len = '0;
    logic             cmd_force_ir = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [DR_W-1:0]  rsp_data;
    logic             rsp_err;
    logic             eng_work;
    logic             eng_op;
    logic [LEN_W-1:0] eng_len;
    logic [IR_W-1:0]  eng_ir;
    logic [DR_W-1:0]  eng_dr;
    logic             eng_done = 1'b0;
    logic [DR_W-1:0]  eng_cap = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jtag_scan_ctrl #(
        .IR_W(IR_W), .DR_W(DR_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
        .cmd_dr(cmd_dr), .cmd_dr_len(cmd_dr_len), .cmd_force_ir(cmd_force_ir),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .eng_work(eng_work), .eng_op(eng_op), .eng_len(eng_len),
        .eng_ir(eng_ir), .eng_dr(eng_dr), .eng_done(eng_done), .eng_cap(eng_cap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command for one cycle; returns at the falling edge after acceptance.
    task automatic send_cmd(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr,
                            input logic [LEN_W-1:0] len, input logic force_ir);
        cmd_valid    = 1'b1;
        cmd_ir       = ir;
        cmd_dr       = dr;
        cmd_dr_len   = len;
        cmd_force_ir = force_ir;
        @(negedge clk);
        cmd_valid    = 1'b0;
        cmd_force_ir = 1'b0;
        $display("cmd ir=0x%0h dr=0x%0h len=%0d force=%0d", ir, dr, len, force_ir);
    endtask

    task automatic pulse_done(input logic [DR_W-1:0] cap);
        eng_done = 1'b1;
        eng_cap  = cap;
        @(negedge clk);
        eng_done = 1'b0;
    endtask

    task automatic take_rsp(input string tag);
        $display("rsp valid=%0d data=0x%0h err=%0d", rsp_valid, rsp_data, rsp_err);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        chk({tag, "_eng_work"},  32'(eng_work),  32'd0);
        chk({tag, "_eng_op"},    32'(eng_op),    32'd0);
        chk({tag, "_eng_len"},   32'(eng_len),   32'd0);
        chk({tag, "_eng_ir"},    32'(eng_ir),    32'd0);
        chk({tag, "_eng_dr"},    32'(eng_dr),    32'd0);
    endtask

    initial begin
        // ---- reset ----
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // ---- full IR + DR scan ----
        send_cmd(10'h19C, 8'hA5, 16'd8, 1'b0);
        chk("t1_cmd_ready_low", 32'(cmd_ready), 32'd0);
        chk("t1_ir_work", 32'(eng_work), 32'd1);
        chk("t1_ir_op",   32'(eng_op),   32'd0);
        chk("t1_ir_len",  32'(eng_len),  32'd10);
        chk("t1_ir_ir",   32'(eng_ir),   32'h19C);
        @(negedge clk);
        chk("t1_irwait_work", 32'(eng_work), 32'd0);
        chk("t1_irwait_len",  32'(eng_len),  32'd10);
        pulse_done(8'h00);
        chk("t1_dr_work", 32'(eng_work), 32'd1);
        chk("t1_dr_op",   32'(eng_op),   32'd1);
        chk("t1_dr_len",  32'(eng_len),  32'd8);
        chk("t1_dr_dr",   32'(eng_dr),   32'hA5);
        @(negedge clk);
        pulse_done(8'h3C);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_data",  32'(rsp_data),  32'h3C);
        chk("t1_rsp_err",   32'(rsp_err),   32'd0);
        take_rsp("t1");

        // ---- IR cache hit: DR scan only, capture masked to 4 bits ----
        send_cmd(10'h19C, 8'h0F, 16'd4, 1'b0);
        chk("t2_work", 32'(eng_work), 32'd1);
        chk("t2_op",   32'(eng_op),   32'd1);
        chk("t2_len",  32'(eng_len),  32'd4);
        chk("t2_dr",   32'(eng_dr),   32'h0F);
        @(negedge clk);
        pulse_done(8'hFF);
        chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t2_rsp_data",  32'(rsp_data),  32'h0F);
        chk("t2_rsp_err",   32'(rsp_err),   32'd0);
        take_rsp("t2");

        // ---- forced IR scan on cached instruction ----
        send_cmd(10'h19C, 8'h33, 16'd8, 1'b1);
        chk("t3_ir_work", 32'(eng_work), 32'd1);
        chk("t3_ir_op",   32'(eng_op),   32'd0);
        chk("t3_ir_len",  32'(eng_len),  32'd10);
        @(negedge clk);
        pulse_done(8'h00);
        chk("t3_dr_work", 32'(eng_work), 32'd1);
        chk("t3_dr_op",   32'(eng_op),   32'd1);
        chk("t3_dr_dr",   32'(eng_dr),   32'h33);
        @(negedge clk);
        pulse_done(8'h5A);
        chk("t3_rsp_data", 32'(rsp_data), 32'h5A);
        take_rsp("t3");

        // ---- illegal lengths 0 and 9 ----
        send_cmd(10'h19C, 8'h77, 16'd0, 1'b0);
        chk("t4a_work",      32'(eng_work),  32'd0);
        chk("t4a_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t4a_rsp_err",   32'(rsp_err),   32'd1);
        chk("t4a_rsp_data",  32'(rsp_data),  32'd0);
        take_rsp("t4a");
        send_cmd(10'h19C, 8'h77, 16'd9, 1'b0);
        chk("t4b_work",      32'(eng_work),  32'd0);
        chk("t4b_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t4b_rsp_err",   32'(rsp_err),   32'd1);
        chk("t4b_rsp_data",  32'(rsp_data),  32'd0);
        take_rsp("t4b");

        // ---- IR scan timeout: error 16 cycles after entering IR_WAIT ----
        send_cmd(10'h19C, 8'h11, 16'd8, 1'b1);
        chk("t5_ir_op", 32'(eng_op), 32'd0);
        @(negedge clk);                 // first IR_WAIT cycle
        repeat (15) @(negedge clk);
        chk("t5_not_yet", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t5_rsp_err",   32'(rsp_err),   32'd1);
        chk("t5_rsp_data",  32'(rsp_data),  32'd0);
        take_rsp("t5");

        // ---- cache invalidated: same IR rescans; done on the expiry cycle wins ----
        send_cmd(10'h19C, 8'h96, 16'd8, 1'b0);
        chk("t6_ir_work", 32'(eng_work), 32'd1);
        chk("t6_ir_op",   32'(eng_op),   32'd0);
        @(negedge clk);
        repeat (15) @(negedge clk);
        pulse_done(8'h00);
        chk("t6_dr_work",   32'(eng_work),  32'd1);
        chk("t6_dr_op",     32'(eng_op),    32'd1);
        chk("t6_no_rsp",    32'(rsp_valid), 32'd0);
        @(negedge clk);
        pulse_done(8'hC3);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t6_rsp_data",  32'(rsp_data),  32'hC3);
        chk("t6_rsp_err",   32'(rsp_err),   32'd0);

        // ---- response held for 5 cycles ----
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t7_hold_valid", 32'(rsp_valid), 32'd1);
            chk("t7_hold_data",  32'(rsp_data),  32'hC3);
            chk("t7_hold_err",   32'(rsp_err),   32'd0);
            chk("t7_hold_ready", 32'(cmd_ready), 32'd0);
        end
        take_rsp("t7");

        // ---- reset asserted during DR_WAIT ----
        send_cmd(10'h19C, 8'h11, 16'd8, 1'b0);
        chk("t8_hit_op", 32'(eng_op), 32'd1);
        @(negedge clk);                 // DR_WAIT
        #2 rst = 1'b0;
        #1 chk_reset_outputs("t8_async");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_cmd(10'h19C, 8'h11, 16'd8, 1'b0);
        chk("t9_ir_work", 32'(eng_work), 32'd1);
        chk("t9_ir_op",   32'(eng_op),   32'd0);
        @(negedge clk);
        pulse_done(8'h00);
        @(negedge clk);
        pulse_done(8'h81);
        chk("t9_rsp_data", 32'(rsp_data), 32'h81);
        take_rsp("t9");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
